// File: rtl/dmem_uart_dump_ctrl.sv
// Port arbiter and dump sequencer for the shared single-port data memory.
// The MEM stage always wins the port; the dump reads word 0 as a count, then streams words 1..N MSB-first.
module dmem_uart_dump_ctrl #(
    parameter int MAX_WORDS = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cpuWriteEn,
    input  logic        cpuReadEn,
    input  logic [31:0] cpuAddress,
    input  logic [31:0] cpuDataIn,
    output logic        memWriteEn,
    output logic        memReadEn,
    output logic [31:0] memAddress,
    output logic [31:0] memDataIn,
    input  logic [31:0] memDataOut,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady,
    output logic        busy,
    output logic        done,
    output logic [2:0]  dbgState
);

    localparam logic [31:0] MAX_W32 = 32'(MAX_WORDS);
    localparam logic [6:0]  MAX_W7  = 7'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_LEN    = 3'd1,
        WAIT_LEN  = 3'd2,
        RD_WORD   = 3'd3,
        WAIT_WORD = 3'd4,
        SEND      = 3'd5,
        DONE      = 3'd6
    } stateT;

    stateT       state;
    stateT       nextState;
    logic [6:0]  idx;
    logic [6:0]  count;
    logic [6:0]  clampedCount;
    logic [31:0] shiftReg;
    logic [1:0]  byteSel;
    logic        cpuHit;
    logic        dumpRead;
    logic        handshake;
    logic        lastByte;
    logic        lastWord;

    assign cpuHit    = cpuReadEn | cpuWriteEn;
    assign dumpRead  = (state == RD_LEN) || (state == RD_WORD);
    // A byte moves on any cycle where txValid and txReady are both high; until then
    // txValid stays high and txData holds its value.
    assign handshake = txValid & txReady;
    assign lastByte  = (byteSel == 2'd3);
    assign lastWord  = (idx == count);
    assign txData    = shiftReg[31:24];
    assign dbgState  = state;

    always_comb begin
        if (memDataOut > MAX_W32) begin
            clampedCount = MAX_W7;
        end else begin
            clampedCount = memDataOut[6:0];
        end
    end

    // The CPU owns the port whenever it asks for it; the dump only uses idle cycles.
    always_comb begin
        memWriteEn = 1'b0;
        memReadEn  = 1'b0;
        memAddress = 32'd0;
        memDataIn  = 32'd0;
        if (cpuHit) begin
            memWriteEn = cpuWriteEn;
            memReadEn  = cpuReadEn;
            memAddress = cpuAddress;
            memDataIn  = cpuDataIn;
        end else if (dumpRead) begin
            memReadEn  = 1'b1;
            memAddress = {25'd0, idx};
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = RD_LEN;
                end
            end
            RD_LEN: begin
                if (!cpuHit) begin
                    nextState = WAIT_LEN;
                end
            end
            WAIT_LEN: begin
                nextState = (clampedCount == 7'd0) ? DONE : RD_WORD;
            end
            RD_WORD: begin
                if (!cpuHit) begin
                    nextState = WAIT_WORD;
                end
            end
            WAIT_WORD: begin
                nextState = SEND;
            end
            SEND: begin
                if (handshake && lastByte) begin
                    nextState = lastWord ? DONE : RD_WORD;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 7'd0;
            count    <= 7'd0;
            shiftReg <= 32'd0;
            byteSel  <= 2'd0;
            txValid  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state   <= nextState;
            txValid <= (nextState == SEND);
            busy    <= (nextState != IDLE);
            done    <= (nextState == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        idx <= 7'd0;
                    end
                end
                WAIT_LEN: begin
                    count <= clampedCount;
                    idx   <= 7'd1;
                end
                // memDataOut is registered, so a CPU access in this cycle cannot disturb it.
                WAIT_WORD: begin
                    shiftReg <= memDataOut;
                    byteSel  <= 2'd0;
                end
                SEND: begin
                    if (handshake) begin
                        shiftReg <= {shiftReg[23:0], 8'h00};
                        byteSel  <= byteSel + 2'd1;
                        if (lastByte && !lastWord) begin
                            idx <= idx + 7'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_uart_dump_ctrl.sv
// Bench for dmem_uart_dump_ctrl: behavioural data memory, byte scoreboard fed from a shadow
// copy of memory, and one task per scenario.
module tb_dmem_uart_dump_ctrl;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_WORD = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cpuWriteEn;
    logic        cpuReadEn;
    logic [31:0] cpuAddress;
    logic [31:0] cpuDataIn;
    logic        memWriteEn;
    logic        memReadEn;
    logic [31:0] memAddress;
    logic [31:0] memDataIn;
    logic [31:0] memDataOut;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic        busy;
    logic        done;
    logic [2:0]  dbgState;

    logic [31:0] mem [0:255];
    logic [31:0] model_mem [0:255];
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_b;

    int n_checks = 0;
    int n_pass = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    logic saw_valid = 1'b0;
    logic saw_addr1 = 1'b0;

    dmem_uart_dump_ctrl #(.MAX_WORDS(63)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cpuWriteEn(cpuWriteEn), .cpuReadEn(cpuReadEn),
        .cpuAddress(cpuAddress), .cpuDataIn(cpuDataIn),
        .memWriteEn(memWriteEn), .memReadEn(memReadEn),
        .memAddress(memAddress), .memDataIn(memDataIn), .memDataOut(memDataOut),
        .txData(txData), .txValid(txValid), .txReady(txReady),
        .busy(busy), .done(done), .dbgState(dbgState)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    // Registered-output memory, as Data_Memory behaves.
    always @(posedge clk) begin
        if (memWriteEn) mem[memAddress[7:0]] <= memDataIn;
        if (memReadEn) memDataOut <= mem[memAddress[7:0]];
    end

    // Scoreboard / monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (txValid && txReady) begin
                hs_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL tx_byte got %02h exp none", txData);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (txData !== exp_b) $display("FAIL tx_byte got %02h exp %02h", txData, exp_b);
                    else n_pass++;
                end
            end
            if (done) done_cnt++;
            if (txValid) saw_valid = 1'b1;
            if (memReadEn && !cpuReadEn && !cpuWriteEn && memAddress == 32'd1) saw_addr1 = 1'b1;
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input int addr, input logic [31:0] data);
        cpuWriteEn = 1'b1;
        cpuAddress = 32'(addr);
        cpuDataIn  = data;
        step();
        cpuWriteEn = 1'b0;
        cpuAddress = 32'd0;
        cpuDataIn  = 32'd0;
        model_mem[addr] = data;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    endtask

    task automatic push_dump_expect();
        int len;
        len = (model_mem[0] > 32'd63) ? 63 : int'(model_mem[0]);
        for (int w = 1; w <= len; w++) push_word(model_mem[w]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic load_full();
        cpu_write(0, 32'd2);
        cpu_write(1, 32'hAAF00FAA);
        cpu_write(2, 32'hAEF039A8);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            if (dbgState == s) break;
            step();
        end
        if (i == budget) begin
            n_checks++;
            $display("FAIL %s got timeout exp state %0d", name, s);
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        int d;
        int i;
        d = done_cnt;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt != d) break;
        end
        if (i == budget) begin
            n_checks++;
            $display("FAIL %s got no done exp done within %0d", name, budget);
        end
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cpuWriteEn = 1'b0; cpuReadEn = 1'b0;
        cpuAddress = 32'd0; cpuDataIn = 32'd0; txReady = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done got %b exp 0", done); else n_pass++;
        n_checks++; if (txValid !== 1'b0) $display("FAIL rst_txValid got %b exp 0", txValid); else n_pass++;
        n_checks++; if (txData !== 8'h00) $display("FAIL rst_txData got %02h exp 00", txData); else n_pass++;
        n_checks++; if (dbgState !== ST_IDLE) $display("FAIL rst_state got %0d exp 0", dbgState); else n_pass++;
        n_checks++; if ({memReadEn, memWriteEn, memAddress, memDataIn} !== 66'd0)
            $display("FAIL rst_mem_idle got %b %b %h %h exp 0", memReadEn, memWriteEn, memAddress, memDataIn);
        else n_pass++;
        cpuReadEn = 1'b1; cpuAddress = 32'h0000_1234; cpuDataIn = 32'hDEAD_BEEF;
        #1;
        n_checks++; if ({memReadEn, memWriteEn, memAddress, memDataIn} !== {2'b10, 32'h0000_1234, 32'hDEAD_BEEF})
            $display("FAIL mirror_read got %b %b %h %h exp 1 0 00001234 deadbeef", memReadEn, memWriteEn, memAddress, memDataIn);
        else n_pass++;
        cpuReadEn = 1'b0;
        step();
    endtask

    task automatic test_full_dump();
        int d0, h0, lat;
        load_full();
        txReady = 1'b1;
        d0 = done_cnt; h0 = hs_cnt;
        push_dump_expect();
        pulse_start();
        n_checks++; if (!(memReadEn === 1'b1 && memAddress === 32'd0))
            $display("FAIL full_len_read got en=%b addr=%h exp en=1 addr=0", memReadEn, memAddress);
        else n_pass++;
        lat = 0;
        while (txValid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        n_checks++; if (lat != 4) $display("FAIL full_latency got %0d exp 4", lat); else n_pass++;
        wait_done(100, "full_done");
        n_checks++; if (done_cnt != d0 + 1) $display("FAIL full_done_cnt got %0d exp %0d", done_cnt - d0, 1); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL full_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (hs_cnt - h0 != 8) $display("FAIL full_bytes got %0d exp 8", hs_cnt - h0); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL full_left got %0d exp 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_empty_dump();
        int d0, e;
        cpu_write(0, 32'd0);
        d0 = done_cnt;
        saw_valid = 1'b0; saw_addr1 = 1'b0;
        pulse_start();
        e = 0;
        while (done !== 1'b1 && e < 10) begin
            step();
            e++;
        end
        n_checks++; if (e != 2) $display("FAIL empty_done_time got %0d exp 2", e); else n_pass++;
        step(); step();
        n_checks++; if (saw_valid !== 1'b0) $display("FAIL empty_txValid got %b exp 0", saw_valid); else n_pass++;
        n_checks++; if (saw_addr1 !== 1'b0) $display("FAIL empty_addr1 got %b exp 0", saw_addr1); else n_pass++;
        n_checks++; if (done_cnt != d0 + 1) $display("FAIL empty_done_cnt got %0d exp 1", done_cnt - d0); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL empty_busy got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_contention();
        int h0, d0;
        load_full();
        h0 = hs_cnt; d0 = done_cnt;
        push_dump_expect();
        pulse_start();
        wait_state(ST_RD_WORD, 10, "cont_reach_rd_word");
        for (int i = 0; i < 5; i++) begin
            cpuReadEn = 1'b1; cpuAddress = 32'd5;
            #1;
            n_checks++; if (!(memReadEn === 1'b1 && memAddress === 32'd5 && dbgState === ST_RD_WORD))
                $display("FAIL cont_cpu_cycle%0d got en=%b addr=%h st=%0d exp en=1 addr=5 st=3", i, memReadEn, memAddress, dbgState);
            else n_pass++;
            step();
        end
        cpuReadEn = 1'b0; cpuAddress = 32'd0;
        #1;
        n_checks++; if (!(memReadEn === 1'b1 && memAddress === 32'd1))
            $display("FAIL cont_first_free got en=%b addr=%h exp en=1 addr=1", memReadEn, memAddress);
        else n_pass++;
        wait_done(200, "cont_done");
        n_checks++; if (hs_cnt - h0 != 8) $display("FAIL cont_bytes got %0d exp 8", hs_cnt - h0); else n_pass++;
        n_checks++; if (done_cnt != d0 + 1) $display("FAIL cont_done_cnt got %0d exp 1", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_backpressure();
        int h0, d0, i;
        load_full();
        h0 = hs_cnt; d0 = done_cnt;
        push_dump_expect();
        pulse_start();
        for (i = 0; i < 50; i++) begin
            if (hs_cnt - h0 == 2) break;
            step();
        end
        n_checks++; if (i == 50) $display("FAIL bp_reach got timeout exp 2 bytes"); else n_pass++;
        txReady = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 3) start = 1'b1;
            if (k == 5) start = 1'b0;
            n_checks++; if (!(txValid === 1'b1 && txData === 8'h0F))
                $display("FAIL bp_hold%0d got v=%b d=%02h exp v=1 d=0f", k, txValid, txData);
            else n_pass++;
        end
        @(posedge clk); #1;
        start = 1'b0;
        txReady = 1'b1;
        wait_done(100, "bp_done");
        n_checks++; if (hs_cnt - h0 != 8) $display("FAIL bp_bytes got %0d exp 8", hs_cnt - h0); else n_pass++;
        n_checks++; if (done_cnt != d0 + 1) $display("FAIL bp_done_cnt got %0d exp 1", done_cnt - d0); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL bp_busy got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid_send();
        int h0, d0, i;
        load_full();
        h0 = hs_cnt;
        push_dump_expect();
        pulse_start();
        for (i = 0; i < 50; i++) begin
            if (hs_cnt - h0 == 1) break;
            step();
        end
        txReady = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        d0 = done_cnt;
        n_checks++; if ({busy, txValid, done} !== 3'b000)
            $display("FAIL midrst_flags got %b%b%b exp 000", busy, txValid, done);
        else n_pass++;
        n_checks++; if (txData !== 8'h00) $display("FAIL midrst_txData got %02h exp 00", txData); else n_pass++;
        n_checks++; if (memReadEn !== 1'b0) $display("FAIL midrst_memReadEn got %b exp 0", memReadEn); else n_pass++;
        n_checks++; if (dbgState !== ST_IDLE) $display("FAIL midrst_state got %0d exp 0", dbgState); else n_pass++;
        repeat (5) step();
        n_checks++; if (done_cnt != d0) $display("FAIL midrst_no_done got %0d exp 0", done_cnt - d0); else n_pass++;
        txReady = 1'b1;
        h0 = hs_cnt;
        push_dump_expect();
        pulse_start();
        n_checks++; if (!(memReadEn === 1'b1 && memAddress === 32'd0))
            $display("FAIL midrst_restart got en=%b addr=%h exp en=1 addr=0", memReadEn, memAddress);
        else n_pass++;
        wait_done(100, "midrst_done");
        n_checks++; if (hs_cnt - h0 != 8) $display("FAIL midrst_bytes got %0d exp 8", hs_cnt - h0); else n_pass++;
        n_checks++; if (done_cnt != d0 + 1) $display("FAIL midrst_done_cnt got %0d exp 1", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_cpu_write_during_dump();
        int h0, d0;
        logic [31:0] new_w2;
        new_w2 = 32'h5A3C_7E01;
        load_full();
        h0 = hs_cnt; d0 = done_cnt;
        push_word(model_mem[1]);
        push_word(new_w2);
        pulse_start();
        wait_state(ST_SEND, 20, "cw_reach_send");
        cpu_write(2, new_w2);
        cpu_write(0, 32'd50);
        wait_done(100, "cw_done");
        n_checks++; if (hs_cnt - h0 != 8) $display("FAIL cw_bytes got %0d exp 8", hs_cnt - h0); else n_pass++;
        n_checks++; if (done_cnt != d0 + 1) $display("FAIL cw_done_cnt got %0d exp 1", done_cnt - d0); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL cw_left got %0d exp 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_count_clamp();
        int h0, d0;
        cpu_write(0, 32'd1000);
        for (int w = 1; w <= 64; w++) cpu_write(w, $urandom);
        h0 = hs_cnt; d0 = done_cnt;
        push_dump_expect();
        pulse_start();
        wait_done(2000, "clamp_done");
        n_checks++; if (hs_cnt - h0 != 252) $display("FAIL clamp_bytes got %0d exp 252", hs_cnt - h0); else n_pass++;
        n_checks++; if (done_cnt != d0 + 1) $display("FAIL clamp_done_cnt got %0d exp 1", done_cnt - d0); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL clamp_left got %0d exp 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_empty_dump();
        test_contention();
        test_backpressure();
        test_reset_mid_send();
        test_cpu_write_during_dump();
        test_count_clamp();
        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
